// File: rtl/iob_2p_assim_fifo_ctrl_pkg.sv
// iob_2p_assim_fifo_ctrl_pkg: width helpers shared by the asymmetric FIFO controller, RAM and wrapper.
package iob_2p_assim_fifo_ctrl_pkg;

    function automatic int max_f(input int a, input int b);
        return a > b ? a : b;
    endfunction

    function automatic int min_f(input int a, input int b);
        return a < b ? a : b;
    endfunction

    function automatic int ratio_f(input int w_data_w, input int r_data_w);
        return max_f(w_data_w, r_data_w) / min_f(w_data_w, r_data_w);
    endfunction

    function automatic int log2_ratio_f(input int w_data_w, input int r_data_w);
        return $clog2(ratio_f(w_data_w, r_data_w));
    endfunction

    function automatic int r_addr_w_f(input int w_addr_w, input int w_data_w, input int r_data_w);
        return w_addr_w - log2_ratio_f(w_data_w, r_data_w);
    endfunction

endpackage

// File: rtl/iob_2p_assim_fifo_ctrl_if.sv
// iob_2p_assim_fifo_ctrl_if: requester handshake, status and RAM address/enable bundle.
interface iob_2p_assim_fifo_ctrl_if #(
    parameter int W_DATA_W = 8,
    parameter int R_DATA_W = 32,
    parameter int W_ADDR_W = 4
);
    import iob_2p_assim_fifo_ctrl_pkg::*;

    localparam int R_ADDR_W = r_addr_w_f(W_ADDR_W, W_DATA_W, R_DATA_W);

    logic                clr;
    logic                w_req;
    logic                w_full;
    logic                r_req;
    logic                r_empty;
    logic                r_valid;
    logic [W_ADDR_W:0]   level;
    logic                w_ovf;
    logic                r_udf;
    logic                mem_w_en;
    logic [W_ADDR_W-1:0] mem_w_addr;
    logic                mem_r_en;
    logic [R_ADDR_W-1:0] mem_r_addr;

    modport master (
        output clr, w_req, r_req,
        input  w_full, r_empty, r_valid, level, w_ovf, r_udf,
        input  mem_w_en, mem_w_addr, mem_r_en, mem_r_addr
    );

    modport slave (
        input  clr, w_req, r_req,
        output w_full, r_empty, r_valid, level, w_ovf, r_udf,
        output mem_w_en, mem_w_addr, mem_r_en, mem_r_addr
    );

endinterface

// File: rtl/iob_2p_assim_fifo_ctrl.sv
// iob_2p_assim_fifo_ctrl: pointer/level controller turning a narrow-write wide-read RAM into a FIFO.
module iob_2p_assim_fifo_ctrl
    import iob_2p_assim_fifo_ctrl_pkg::*;
#(
    parameter int W_DATA_W = 8,
    parameter int R_DATA_W = 32,
    parameter int W_ADDR_W = 4
) (
    input logic                clk,
    input logic                rst,
    iob_2p_assim_fifo_ctrl_if.slave bus
);

    localparam int RATIO    = ratio_f(W_DATA_W, R_DATA_W);
    localparam int R_ADDR_W = r_addr_w_f(W_ADDR_W, W_DATA_W, R_DATA_W);
    localparam int DEPTH    = 2 ** W_ADDR_W;

    typedef logic [W_ADDR_W:0] level_t;

    logic [W_ADDR_W-1:0] wptr;
    logic [R_ADDR_W-1:0] rptr;
    level_t              level;
    logic                r_valid, w_ovf, r_udf;
    logic                w_full, r_empty, push_ok, pop_ok;

    // flags use the current level only; rst also blocks enables so nothing is written mid-reset
    always_comb begin
        w_full  = level == level_t'(DEPTH);
        r_empty = level < level_t'(RATIO);
        push_ok = bus.w_req & ~w_full & ~bus.clr & ~rst;
        pop_ok  = bus.r_req & ~r_empty & ~bus.clr & ~rst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            r_valid <= 1'b0;
            w_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (bus.clr) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            r_valid <= 1'b0;
            w_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            wptr    <= wptr + W_ADDR_W'(push_ok);
            rptr    <= rptr + R_ADDR_W'(pop_ok);
            level   <= level + level_t'(push_ok) - (pop_ok ? level_t'(RATIO) : '0);
            r_valid <= pop_ok;
            w_ovf   <= w_ovf | (bus.w_req & w_full);
            r_udf   <= r_udf | (bus.r_req & r_empty);
        end
    end

    assign bus.w_full     = w_full;
    assign bus.r_empty    = r_empty;
    assign bus.r_valid    = r_valid;
    assign bus.level      = level;
    assign bus.w_ovf      = w_ovf;
    assign bus.r_udf      = r_udf;
    assign bus.mem_w_en   = push_ok;
    assign bus.mem_w_addr = wptr;
    assign bus.mem_r_en   = pop_ok;
    assign bus.mem_r_addr = rptr;

endmodule
